seg7_scan: RTL and testbench

- Time-multiplexed 8-digit seven-segment display driver; first consumer of the free-running clock-divider bus.
- Takes one divider bit as the scan-rate source and a slower divider bit as the blink source.
- Displays a 32-bit hex word (digit 0 = bits [3:0]) with per-digit decimal points and per-digit blink.
- Sits between the CPU debug/display mux and the board's anode/segment pins.

---
 rtl/seg7_scan_pkg.sv | 9 +
 rtl/seg7_scan_if.sv | 13 +
 rtl/seg7_hexdec.sv | 9 +
 rtl/seg7_scan.sv | 64 ++++++
 tb/tb_seg7_scan.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: shared seven-segment constants.
// Segment order is {dp,g,f,e,d,c,b,a}. Table values are active-high.
package seg7_scan_pkg;
    localparam int SEG_DP = 7;
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: display data in, scan control in, pin drives out.
interface seg7_scan_if;
    logic        scan_src;
    logic        blink_src;
    logic [31:0] hexs;
    logic [7:0]  points;
    logic [7:0]  le;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [2:0]  scan_idx;
    modport master (output scan_src, blink_src, hexs, points, le, input an, seg, scan_idx);
    modport slave (input scan_src, blink_src, hexs, points, le, output an, seg, scan_idx);
endinterface

// File: rtl/seg7_hexdec.sv
// seg7_hexdec: hex nibble to active-high {g..a} segments.
module seg7_hexdec
    import seg7_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);
    assign segs = HEX_SEG[nibble];
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: 8-digit multiplexed seven-segment driver with per-frame snapshot,
// decimal points and blink; pins are registered two cycles after a scan tick.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter bit ACTIVE_LOW = 1
) (
    input logic       clk,
    input logic       rst,
    seg7_scan_if.slave bus
);
    localparam logic [7:0] OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
    logic        scan_prev;
    logic [2:0]  idx;
    logic [31:0] hexs_snap;
    logic [7:0]  points_snap;
    logic [7:0]  le_snap;
    logic [7:0]  an_r;
    logic [7:0]  seg_r;
    logic [7:0]  an_n;
    logic [7:0]  seg_n;
    logic [6:0]  dec;
    logic        tick;
    logic        blank;
    assign tick  = bus.scan_src & ~scan_prev;
    assign blank = le_snap[idx] & bus.blink_src;
    seg7_hexdec u_dec (
        .nibble(hexs_snap[{idx, 2'b00} +: 4]),
        .segs  (dec)
    );
    always_comb begin
        seg_n         = {1'b0, dec};
        seg_n[SEG_DP] = points_snap[idx];
        an_n          = blank ? 8'h00 : 8'h01 << idx;
        seg_n         = blank ? 8'h00 : seg_n;
    end
    // Snapshot is taken on the wrap tick so a frame never mixes two input words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_prev   <= 1'b0;
            idx         <= 3'd0;
            hexs_snap   <= '0;
            points_snap <= '0;
            le_snap     <= '0;
            an_r        <= OFF;
            seg_r       <= OFF;
        end else begin
            scan_prev <= bus.scan_src;
            if (tick)
                idx <= idx + 3'd1;
            if (tick && idx == 3'(DIGITS - 1)) begin
                hexs_snap   <= bus.hexs;
                points_snap <= bus.points;
                le_snap     <= bus.le;
            end
            an_r  <= an_n ^ OFF;
            seg_r <= seg_n ^ OFF;
        end
    end
    assign bus.an       = an_r;
    assign bus.seg      = seg_r;
    assign bus.scan_idx = idx;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed and random stimulus against a frame-level display model.
module tb_seg7_scan;
    logic clk = 1'b0;
    logic rst = 1'b0;
    seg7_scan_if bus();
    seg7_scan #(.DIGITS(8), .ACTIVE_LOW(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int errors = 0;
    int checks = 0;
    int ph = 0;
    // model: current digit, last scan level, frame snapshot, expected pins
    int          m_idx = 0;
    logic        m_prev = 1'b0;
    logic [31:0] m_hexs = '0;
    logic [7:0]  m_points = '0;
    logic [7:0]  m_le = '0;
    logic [7:0]  m_an = 8'hFF;
    logic [7:0]  m_seg = 8'hFF;

    function automatic logic [15:0] pins(int d, logic [31:0] h, logic [7:0] p, logic [7:0] l, logic b);
        logic [7:0] a;
        if (l[d] && b) return 16'hFFFF;
        a = 8'd1 << d;
        return {~a, ~{p[d], tbl[h[4*d +: 4]]}};
    endfunction

    task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_prev = 1'b0; m_hexs = '0; m_points = '0; m_le = '0;
        m_an = 8'hFF; m_seg = 8'hFF;
    endtask

    task automatic cyc();
        logic [15:0] nxt;
        logic tk;
        logic [31:0] h;
        logic [7:0] p, l;
        nxt = pins(m_idx, m_hexs, m_points, m_le, bus.blink_src);
        tk  = bus.scan_src && !m_prev;
        h = bus.hexs; p = bus.points; l = bus.le;
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            m_prev = bus.scan_src;
            if (tk) begin
                if (m_idx == 7) begin m_hexs = h; m_points = p; m_le = l; end
                m_idx = (m_idx + 1) % 8;
            end
            {m_an, m_seg} = nxt;
        end
        #1;
        check("an", bus.an, m_an);
        check("seg", bus.seg, m_seg);
        check("scan_idx", {5'd0, bus.scan_idx}, 8'(m_idx));
    endtask

    task automatic tog();
        bus.scan_src = (ph % 4) < 2;
        ph++;
        cyc();
    endtask

    task automatic wait_idx(int k);
        bit found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (int'(bus.scan_idx) == k) found = 1;
            else tog();
        end
        checks++;
        assert (found) else begin errors++; $error("FAIL wait_idx %0d: got %0d expected %0d", k, bus.scan_idx, k); end
    endtask

    task automatic wait_pins(int k);
        bit found = 0;
        logic [7:0] a;
        a = ~(8'd1 << k);
        for (int i = 0; i < 64 && !found; i++) begin
            if (bus.an === a) found = 1;
            else tog();
        end
        checks++;
        assert (found) else begin errors++; $error("FAIL wait_pins %0d: an %h expected %h", k, bus.an, a); end
    endtask

    initial begin
        logic [7:0] a0;
        int r;
        bus.scan_src = 0; bus.blink_src = 0; bus.hexs = '0; bus.points = '0; bus.le = '0;
        model_reset();
        repeat (3) cyc();
        check("reset an", bus.an, 8'hFF);
        check("reset seg", bus.seg, 8'hFF);
        rst = 1'b1;
        repeat (3) cyc();
        check("idle idx", {5'd0, bus.scan_idx}, 8'd0);
        check("idle an", bus.an, 8'hFE);
        check("idle seg", bus.seg, 8'hC0);

        bus.hexs = 32'h76543210;
        wait_idx(7); wait_idx(0);
        for (int k = 1; k < 8; k++) wait_pins(k);
        wait_pins(0);
        check("digit0 seg", bus.seg, 8'hC0);
        wait_pins(1);
        check("digit1 seg", bus.seg, 8'hF9);
        // latency: pins move on the second edge after the scan rise
        bus.scan_src = 0; repeat (2) cyc();
        a0 = bus.an;
        bus.scan_src = 1; cyc();
        check("latency hold", bus.an, a0);
        cyc();
        check("latency new", bus.an, 8'hFB);
        check("latency seg", bus.seg, 8'hA4);

        bus.hexs = 32'h11111111;
        wait_idx(7); wait_idx(0); wait_idx(3);
        bus.hexs = 32'h22222222;
        wait_pins(5);
        check("snap old", bus.seg, 8'hF9);
        wait_pins(0);
        check("snap new0", bus.seg, 8'hA4);
        wait_pins(1);
        check("snap new1", bus.seg, 8'hA4);

        bus.hexs = 32'hFFFFFFFF; bus.points = 8'h01;
        wait_idx(7); wait_idx(0);
        wait_pins(0);
        check("dp digit0", bus.seg, 8'h0E);
        wait_pins(3);
        check("dp digit3", bus.seg, 8'h8E);

        bus.hexs = 32'h76543210; bus.points = 8'h00; bus.le = 8'h04;
        wait_idx(7); wait_idx(0);
        bus.blink_src = 1;
        wait_idx(2);
        bus.scan_src = 0; cyc(); cyc();
        check("blink an", bus.an, 8'hFF);
        check("blink seg", bus.seg, 8'hFF);
        bus.blink_src = 0; cyc();
        check("unblink an", bus.an, 8'hFB);
        check("unblink seg", bus.seg, 8'hA4);
        bus.blink_src = 1;
        wait_pins(3);
        check("blink other", bus.seg, 8'hB0);
        bus.blink_src = 0;

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) bus.hexs = $urandom;
            if ($urandom_range(15) == 0) bus.points = 8'($urandom);
            if ($urandom_range(15) == 0) bus.le = 8'($urandom);
            if ($urandom_range(5) == 0) bus.blink_src = ~bus.blink_src;
            bus.scan_src = 1'($urandom_range(1));
            cyc();
        end

        bus.scan_src = 0; repeat (2) cyc();
        r = int'(bus.scan_idx);
        bus.scan_src = 1; repeat (50) cyc();
        check("held src", {5'd0, bus.scan_idx}, 8'((r + 1) % 8));

        bus.le = 8'h00; bus.blink_src = 0;
        wait_idx(5);
        #2 rst = 1'b0;
        #1;
        check("async an", bus.an, 8'hFF);
        check("async seg", bus.seg, 8'hFF);
        check("async idx", {5'd0, bus.scan_idx}, 8'd0);
        model_reset();
        bus.scan_src = 0;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        check("post reset seg", bus.seg, 8'hC0);
        repeat (20) tog();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
